// File: rtl/seg_display_scan.sv
// Multiplexed N-digit hex 7-segment driver: per-frame source snapshot, scanned digits, registered pins updated on each scan tick.
// Optional auto-cycle through sources when DISP_AUTOCYCLE_EN is defined (auto_en otherwise ignored).
module seg_display_scan #(
  parameter int NDIGITS  = 4,
  parameter int NSRC     = 6,
  parameter int SCAN_DIV = 1000,
  parameter int AUTO_DIV = 50_000_000
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NSRC*4*NDIGITS-1:0] src_data,
  input  logic [2:0]                sel,
  input  logic                      hold,
  input  logic                      blank,
  input  logic                      auto_en,
  output logic [6:0]                seg,
  output logic                      dp,
  output logic [NDIGITS-1:0]        an,
  output logic [2:0]                cur_sel
);

  localparam int DW = (NDIGITS > 1) ? $clog2(NDIGITS) : 1;
  localparam int PW = $clog2(SCAN_DIV);
  localparam int SW = 4 * NDIGITS;

  function automatic logic [6:0] hex7(input logic [3:0] v);
    case (v)
      4'h0: hex7 = 7'b1000000;
      4'h1: hex7 = 7'b1111001;
      4'h2: hex7 = 7'b0100100;
      4'h3: hex7 = 7'b0110000;
      4'h4: hex7 = 7'b0011001;
      4'h5: hex7 = 7'b0010010;
      4'h6: hex7 = 7'b0000010;
      4'h7: hex7 = 7'b1111000;
      4'h8: hex7 = 7'b0000000;
      4'h9: hex7 = 7'b0010000;
      4'hA: hex7 = 7'b0001000;
      4'hB: hex7 = 7'b0000011;
      4'hC: hex7 = 7'b1000110;
      4'hD: hex7 = 7'b0100001;
      4'hE: hex7 = 7'b0000110;
      default: hex7 = 7'b0001110;
    endcase
  endfunction

  logic [PW-1:0] pre_q;
  logic [DW-1:0] digit_q, digit_nxt;
  logic [SW-1:0] snap_q, snap_nxt;
  logic [2:0]    sel_nxt, eff_sel;
  logic          tick, frame_start;
  logic [3:0]    nib;

  assign tick        = (pre_q == PW'(SCAN_DIV - 1));
  assign frame_start = tick && (digit_q == DW'(NDIGITS - 1));

`ifdef DISP_AUTOCYCLE_EN
  localparam int AW = $clog2(AUTO_DIV);
  logic [AW-1:0] auto_pre_q;
  logic [2:0]    auto_q;
  logic          auto_tick;

  assign auto_tick = auto_en && (auto_pre_q == AW'(AUTO_DIV - 1));
  // Frame-start latch reads auto_q before this edge's step, so a coincident step lands next frame.
  assign eff_sel   = auto_en ? auto_q : sel;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      auto_pre_q <= '0;
      auto_q     <= '0;
    end else if (auto_en) begin
      auto_pre_q <= auto_tick ? '0 : auto_pre_q + 1'b1;
      if (auto_tick)
        auto_q <= (auto_q == 3'(NSRC - 1)) ? 3'd0 : auto_q + 3'd1;
    end
  end
`else
  logic unused_auto_en;
  assign unused_auto_en = auto_en;
  assign eff_sel        = sel;
`endif

  always_comb begin
    sel_nxt   = cur_sel;
    snap_nxt  = snap_q;
    digit_nxt = digit_q;
    if (tick)
      digit_nxt = (digit_q == DW'(NDIGITS - 1)) ? '0 : digit_q + 1'b1;
    if (frame_start && !hold) begin
      sel_nxt  = eff_sel;
      snap_nxt = '0;
      for (int k = 0; k < NSRC; k++)
        if (eff_sel == 3'(k)) snap_nxt = src_data[k*SW +: SW];
    end
    nib = snap_nxt[4*digit_nxt +: 4];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pre_q   <= '0;
      digit_q <= '0;
      snap_q  <= '0;
      cur_sel <= '0;
      seg     <= 7'b1111111;
      dp      <= 1'b1;
      an      <= '1;
    end else begin
      pre_q   <= tick ? '0 : pre_q + 1'b1;
      digit_q <= digit_nxt;
      snap_q  <= snap_nxt;
      cur_sel <= sel_nxt;
      // Pins follow the new digit index on the same edge it advances.
      if (tick) begin
        seg <= (int'(sel_nxt) >= NSRC) ? 7'b0111111 : hex7(nib);
        dp  <= !(hold && (digit_nxt == '0));
        an  <= blank ? '1 : ~(NDIGITS'(1) << digit_nxt);
      end
    end
  end

endmodule

// File: tb/tb_seg_display_scan.sv
// Directed bench for seg_display_scan (NDIGITS=4, SCAN_DIV=4, NSRC=6, AUTO_DIV=40).
module tb_seg_display_scan;
  localparam int ND = 4, NS = 6;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [NS*4*ND-1:0] src_data;
  logic [2:0]        sel;
  logic              hold, blank, auto_en;
  logic [6:0]        seg;
  logic              dp;
  logic [ND-1:0]     an;
  logic [2:0]        cur_sel;

  int vectors = 0;
  int fails   = 0;

  seg_display_scan #(.NDIGITS(ND), .NSRC(NS), .SCAN_DIV(4), .AUTO_DIV(40)) dut (
    .clk(clk), .rst_n(rst_n), .src_data(src_data), .sel(sel), .hold(hold),
    .blank(blank), .auto_en(auto_en), .seg(seg), .dp(dp), .an(an), .cur_sel(cur_sel)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    vectors++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic set_src(input int k, input logic [15:0] v);
    src_data[k*16 +: 16] = v;
  endtask

  initial begin
    rst_n = 1'b0; sel = 3'd1; hold = 1'b0; blank = 1'b0; auto_en = 1'b0;
    src_data = '0;
    set_src(1, 16'h1234);
    set_src(2, 16'h00A5);
    cyc(1);
    check("rst_seg", 16'(seg), 16'h7F);
    check("rst_an", 16'(an), 16'hF);
    check("rst_dp", 16'(dp), 16'h1);
    check("rst_cur_sel", 16'(cur_sel), 16'h0);

    // Release, then reset again mid-scan at cycle 7.
    rst_n = 1'b1;
    cyc(7);
    check("pre_reset_an", 16'(an), 16'hD);
    rst_n = 1'b0;
    #1;
    check("midrst_an", 16'(an), 16'hF);
    check("midrst_seg", 16'(seg), 16'h7F);
    check("midrst_cur_sel", 16'(cur_sel), 16'h0);
    @(negedge clk);
    rst_n = 1'b1;
    cyc(3);
    check("first_tick_not_yet", 16'(an), 16'hF);
    cyc(1);                                   // P=4
    check("first_tick_an", 16'(an), 16'hD);
    check("first_tick_seg_zero", 16'(seg), 16'h40);
    cyc(4);                                   // P=8
    check("scan_an_d2", 16'(an), 16'hB);
    cyc(4);                                   // P=12
    check("scan_an_d3", 16'(an), 16'h7);

    // First frame start loads source 1.
    cyc(4);                                   // P=16
    check("frame_an_d0", 16'(an), 16'hE);
    check("frame_seg_4", 16'(seg), 16'h19);
    check("frame_cur_sel", 16'(cur_sel), 16'h1);
    check("frame_dp", 16'(dp), 16'h1);
    cyc(4);                                   // P=20
    check("d1_an", 16'(an), 16'hD);
    check("d1_seg_3", 16'(seg), 16'h30);
    cyc(4);                                   // P=24
    check("d2_seg_2", 16'(seg), 16'h24);
    cyc(4);                                   // P=28
    check("d3_seg_1", 16'(seg), 16'h79);
    cyc(4);                                   // P=32
    check("repeat_an", 16'(an), 16'hE);
    check("repeat_seg_4", 16'(seg), 16'h19);

    // Out-of-range select, then mid-frame change.
    sel = 3'd6;
    cyc(4);                                   // P=36
    check("oor_pending_sel", 16'(cur_sel), 16'h1);
    check("oor_pending_seg", 16'(seg), 16'h30);
    cyc(12);                                  // P=48
    check("oor_cur_sel", 16'(cur_sel), 16'h6);
    check("oor_dash_d0", 16'(seg), 16'h3F);
    sel = 3'd2;
    cyc(4);                                   // P=52
    check("midframe_dash_d1", 16'(seg), 16'h3F);
    check("midframe_cur_sel", 16'(cur_sel), 16'h6);
    cyc(12);                                  // P=64
    check("src2_cur_sel", 16'(cur_sel), 16'h2);
    check("src2_seg_5", 16'(seg), 16'h12);
    cyc(4);                                   // P=68
    check("src2_seg_A", 16'(seg), 16'h08);

    // Hold freezes snapshot and lights dp on digit 0.
    sel = 3'd1;
    cyc(12);                                  // P=80
    check("back_src1_seg", 16'(seg), 16'h19);
    hold = 1'b1;
    set_src(1, 16'hBEEF);
    cyc(4);                                   // P=84
    check("hold_d1_seg", 16'(seg), 16'h30);
    check("hold_d1_dp", 16'(dp), 16'h1);
    cyc(12);                                  // P=96
    check("hold_frame_seg", 16'(seg), 16'h19);
    check("hold_frame_dp", 16'(dp), 16'h0);
    check("hold_cur_sel", 16'(cur_sel), 16'h1);
    cyc(4);                                   // P=100
    check("hold_d1b_seg", 16'(seg), 16'h30);
    hold = 1'b0;
    cyc(12);                                  // P=112
    check("release_seg_F", 16'(seg), 16'h0E);
    check("release_dp", 16'(dp), 16'h1);
    cyc(4);                                   // P=116
    check("release_seg_E", 16'(seg), 16'h06);
    cyc(8);                                   // P=124
    check("release_seg_b", 16'(seg), 16'h03);

    // Blank: takes effect at next tick, scan continues underneath.
    blank = 1'b1;
    cyc(1);
    check("blank_before_tick", 16'(an), 16'h7);
    cyc(3);                                   // P=128
    check("blank_an", 16'(an), 16'hF);
    cyc(4);                                   // P=132
    check("blank_an2", 16'(an), 16'hF);
    blank = 1'b0;
    cyc(4);                                   // P=136
    check("unblank_an_d2", 16'(an), 16'hB);
    check("unblank_seg_E", 16'(seg), 16'h06);

`ifdef DISP_AUTOCYCLE_EN
    auto_en = 1'b1;
    sel = 3'd3;
    cyc(8);                                   // P=144
    check("auto_fs144", 16'(cur_sel), 16'h0);
    cyc(32);                                  // P=176, step coincides with frame start
    check("auto_coincide", 16'(cur_sel), 16'h0);
    cyc(16);                                  // P=192
    check("auto_1", 16'(cur_sel), 16'h1);
    cyc(32);                                  // P=224
    check("auto_2", 16'(cur_sel), 16'h2);
    cyc(48);                                  // P=272
    check("auto_3", 16'(cur_sel), 16'h3);
    cyc(32);                                  // P=304
    check("auto_4", 16'(cur_sel), 16'h4);
    cyc(48);                                  // P=352
    check("auto_5", 16'(cur_sel), 16'h5);
    cyc(32);                                  // P=384
    check("auto_wrap", 16'(cur_sel), 16'h0);
    auto_en = 1'b0;
    cyc(16);                                  // P=400
    check("auto_off_sel", 16'(cur_sel), 16'h3);
`else
    auto_en = 1'b1;
    sel = 3'd3;
    cyc(8);                                   // P=144
    check("auto_ignored_sel", 16'(cur_sel), 16'h3);
    check("auto_ignored_seg", 16'(seg), 16'h40);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end
endmodule
